// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the IF/DEC elastic skid stage
package pipe_pkg;

   localparam int DEF_ADDRESS_WIDTH = 32;
   localparam int DEF_DATA_WIDTH    = 22;
   localparam int DEF_NUM_SLOTS     = 4;
   localparam int DEF_THREAD_WIDTH  = 2;

   typedef logic [DEF_THREAD_WIDTH-1:0] thread_t;

   // Default-width fetch bundle; thread sits in the LSBs so entries can find it generically
   typedef struct packed {
      logic [DEF_ADDRESS_WIDTH-1:0]              pc;
      logic [DEF_NUM_SLOTS*DEF_DATA_WIDTH-1:0]   lanes;
      logic                                      prediction;
      logic [DEF_ADDRESS_WIDTH-1:0]              target;
      thread_t                                   thread;
   } fetch_bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   function automatic occ_e occ_of(input logic head_valid, input logic skid_valid);
      if (skid_valid) return FULL;
      if (head_valid) return ONE;
      return EMPTY;
   endfunction

endpackage

// File: rtl/pipe_bundle_reg.sv
// rtl/pipe_bundle_reg.sv - one valid+payload entry with load, clear and per-thread flush match
module pipe_bundle_reg
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_WIDTH = 8,
   parameter int THREAD_WIDTH  = 2,
   parameter int NUM_THREADS   = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     load,
   input  logic                     clear,
   input  logic [PAYLOAD_WIDTH-1:0] d,
   input  logic [NUM_THREADS-1:0]   flush_mask,
   output logic                     valid,
   output logic [PAYLOAD_WIDTH-1:0] q,
   output logic                     flush_hit
);

   // Thread IDs outside NUM_THREADS never match a mask bit
   always_comb begin
      flush_hit = 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (q[THREAD_WIDTH-1:0] == THREAD_WIDTH'(t)) flush_hit = valid & flush_mask[t];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (clear) begin
         valid <= 1'b0;
         q     <= '0;
      end
   end

endmodule

// File: rtl/pipe_if_dec_skid.sv
// rtl/pipe_if_dec_skid.sv - two-entry IF/DEC skid stage with per-thread flush; PIPE_IF_DEC_STALL_CNT_EN adds a stall counter
module pipe_if_dec_skid
   import pipe_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 22,
   parameter int NUM_SLOTS     = 4,
   parameter int NUM_THREADS   = 4,
   parameter int THREAD_WIDTH  = 2
) (
   input  logic                            i_Clk,
   input  logic                            i_Reset_n,
   input  logic                            i_Valid,
   output logic                            o_Ready,
   input  logic [ADDRESS_WIDTH-1:0]        i_PC,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] i_Instruction,
   input  logic                            i_prediction,
   input  logic [ADDRESS_WIDTH-1:0]        i_branch_target,
   input  logic [THREAD_WIDTH-1:0]         i_thread,
   input  logic [NUM_THREADS-1:0]          i_Flush_Mask,
   output logic                            o_Valid,
   input  logic                            i_Ready,
   output logic [ADDRESS_WIDTH-1:0]        o_PC,
   output logic [NUM_SLOTS*DATA_WIDTH-1:0] o_Instruction,
   output logic                            o_prediction,
   output logic [ADDRESS_WIDTH-1:0]        o_branch_target,
   output logic [THREAD_WIDTH-1:0]         o_thread,
`ifdef PIPE_IF_DEC_STALL_CNT_EN
   input  logic                            i_Stall_Count_Clr,
   output logic [15:0]                     o_Stall_Count,
`endif
   output logic [1:0]                      o_Occupancy
);

   if (NUM_THREADS > (1 << THREAD_WIDTH)) begin : g_thread_width_check
      $error("NUM_THREADS exceeds 2**THREAD_WIDTH");
   end
   if (NUM_SLOTS < 1 || NUM_THREADS < 1) begin : g_size_check
      $error("NUM_SLOTS and NUM_THREADS must be at least 1");
   end

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0]        pc;
      logic [NUM_SLOTS*DATA_WIDTH-1:0] lanes;
      logic                            prediction;
      logic [ADDRESS_WIDTH-1:0]        target;
      logic [THREAD_WIDTH-1:0]         thread;
   } bundle_t;

   localparam int PAYLOAD_WIDTH = $bits(bundle_t);

   bundle_t incoming, head_d, head_q, skid_q;
   logic    head_valid, skid_valid, head_hit, skid_hit, in_hit;
   logic    head_load, head_clear, skid_load, skid_clear;
   logic    accept, release_head, keep_head, keep_skid, take_in;

   assign incoming = '{pc: i_PC, lanes: i_Instruction, prediction: i_prediction,
                       target: i_branch_target, thread: i_thread};

   assign o_Ready      = !skid_valid;
   assign o_Valid      = head_valid;
   assign accept       = i_Valid & o_Ready;
   assign release_head = head_valid & i_Ready;

   always_comb begin
      in_hit = 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (i_thread == THREAD_WIDTH'(t)) in_hit = i_Flush_Mask[t];
      end
   end

   // Survivors in FIFO order (head, skid, incoming) are packed toward head
   always_comb begin
      keep_head  = head_valid & ~release_head & ~head_hit;
      keep_skid  = skid_valid & ~skid_hit;
      take_in    = accept & ~in_hit;
      head_d     = incoming;
      head_load  = 1'b0;
      head_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (keep_head) begin
         if (!keep_skid) begin
            skid_load  = take_in;
            skid_clear = ~take_in;
         end
      end else if (keep_skid) begin
         head_load  = 1'b1;
         head_d     = skid_q;
         skid_clear = 1'b1;
      end else if (take_in) begin
         head_load  = 1'b1;
         skid_clear = 1'b1;
      end else begin
         head_clear = 1'b1;
         skid_clear = 1'b1;
      end
   end

   pipe_bundle_reg #(.PAYLOAD_WIDTH(PAYLOAD_WIDTH), .THREAD_WIDTH(THREAD_WIDTH), .NUM_THREADS(NUM_THREADS)) u_head (
      .clk(i_Clk), .resetn(i_Reset_n), .load(head_load), .clear(head_clear), .d(head_d),
      .flush_mask(i_Flush_Mask), .valid(head_valid), .q(head_q), .flush_hit(head_hit)
   );

   pipe_bundle_reg #(.PAYLOAD_WIDTH(PAYLOAD_WIDTH), .THREAD_WIDTH(THREAD_WIDTH), .NUM_THREADS(NUM_THREADS)) u_skid (
      .clk(i_Clk), .resetn(i_Reset_n), .load(skid_load), .clear(skid_clear), .d(incoming),
      .flush_mask(i_Flush_Mask), .valid(skid_valid), .q(skid_q), .flush_hit(skid_hit)
   );

   assign o_PC            = head_q.pc;
   assign o_Instruction   = head_q.lanes;
   assign o_prediction    = head_q.prediction;
   assign o_branch_target = head_q.target;
   assign o_thread        = head_q.thread;
   assign o_Occupancy     = occ_of(head_valid, skid_valid);

`ifdef PIPE_IF_DEC_STALL_CNT_EN
   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n || i_Stall_Count_Clr) begin
         o_Stall_Count <= '0;
      end else if (o_Valid && !i_Ready && o_Stall_Count != 16'hFFFF) begin
         o_Stall_Count <= o_Stall_Count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_if_dec_skid.sv
// tb/tb_pipe_if_dec_skid.sv - directed vector bench for pipe_if_dec_skid
module tb_pipe_if_dec_skid;

   logic        clk = 1'b0;
   logic        rstn, vin, rdy, pred;
   logic [31:0] pc, tgt;
   logic [87:0] instr;
   logic [1:0]  th;
   logic [3:0]  flush;
   logic        ovalid, ordy, opred;
   logic [31:0] opc, otgt;
   logic [87:0] oinstr;
   logic [1:0]  oth, occ;
`ifdef PIPE_IF_DEC_STALL_CNT_EN
   logic        clr;
   logic [15:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_if_dec_skid dut (
      .i_Clk(clk), .i_Reset_n(rstn), .i_Valid(vin), .o_Ready(ordy), .i_PC(pc),
      .i_Instruction(instr), .i_prediction(pred), .i_branch_target(tgt), .i_thread(th),
      .i_Flush_Mask(flush), .o_Valid(ovalid), .i_Ready(rdy), .o_PC(opc),
      .o_Instruction(oinstr), .o_prediction(opred), .o_branch_target(otgt), .o_thread(oth),
`ifdef PIPE_IF_DEC_STALL_CNT_EN
      .i_Stall_Count_Clr(clr), .o_Stall_Count(stall_cnt),
`endif
      .o_Occupancy(occ)
   );

   typedef struct {
      logic        rstn, v, r;
      logic [31:0] pc;
      logic [1:0]  th;
      logic [3:0]  fl;
      logic        ev, erdy;
      logic [1:0]  eocc;
      logic [31:0] epc;
      logic [1:0]  eth;
   } vec_t;

   function automatic vec_t mk(logic r_n, logic v, logic r, logic [31:0] p, logic [1:0] t, logic [3:0] f,
                               logic ev, logic erdy, logic [1:0] eocc, logic [31:0] epc, logic [1:0] eth);
      vec_t x;
      x.rstn = r_n; x.v = v; x.r = r; x.pc = p; x.th = t; x.fl = f;
      x.ev = ev; x.erdy = erdy; x.eocc = eocc; x.epc = epc; x.eth = eth;
      return x;
   endfunction

   // Payload fields are tied to the PC so a moved bundle carries a recognisable signature
   function automatic logic [87:0] lanes_of(logic [31:0] p);
      logic [87:0] l;
      for (int k = 0; k < 4; k++) l[k*22 +: 22] = 22'(p + 32'(k + 1));
      return l;
   endfunction

   task automatic drive(logic r_n, logic v, logic r, logic [31:0] p, logic [1:0] t, logic [3:0] f);
      rstn = r_n; vin = v; rdy = r; pc = p; th = t; flush = f;
      instr = lanes_of(p); pred = p[4]; tgt = p + 32'h1000;
   endtask

   task automatic check(string name, logic [159:0] act, logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   vec_t vecs[26];
   logic [159:0] act, exp;

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0);
`ifdef PIPE_IF_DEC_STALL_CNT_EN
      clr = 1'b0;
`endif
      //              rstn v  r  pc        th  flush   ev erdy occ epc      eth
      vecs[0]  = mk(0, 1, 0, 32'h55,  0, 4'b0000, 0, 1, 0, 32'h0,   0);
      vecs[1]  = mk(1, 1, 1, 32'h100, 1, 4'b0000, 1, 1, 1, 32'h100, 1);
      vecs[2]  = mk(1, 0, 1, 32'h0,   0, 4'b0000, 0, 1, 0, 32'h0,   0);
      vecs[3]  = mk(1, 1, 0, 32'h10,  0, 4'b0000, 1, 1, 1, 32'h10,  0);
      vecs[4]  = mk(1, 1, 0, 32'h20,  0, 4'b0000, 1, 0, 2, 32'h10,  0);
      vecs[5]  = mk(1, 1, 0, 32'h30,  0, 4'b0000, 1, 0, 2, 32'h10,  0);
      vecs[6]  = mk(1, 1, 1, 32'h30,  0, 4'b0000, 1, 1, 1, 32'h20,  0);
      vecs[7]  = mk(1, 1, 0, 32'h30,  0, 4'b0000, 1, 0, 2, 32'h20,  0);
      vecs[8]  = mk(1, 0, 1, 32'h0,   0, 4'b0000, 1, 1, 1, 32'h30,  0);
      vecs[9]  = mk(1, 0, 1, 32'h0,   0, 4'b0000, 0, 1, 0, 32'h0,   0);
      vecs[10] = mk(1, 1, 0, 32'h40,  0, 4'b0000, 1, 1, 1, 32'h40,  0);
      vecs[11] = mk(1, 1, 0, 32'h50,  2, 4'b0000, 1, 0, 2, 32'h40,  0);
      vecs[12] = mk(1, 0, 0, 32'h0,   0, 4'b0001, 1, 1, 1, 32'h50,  2);
      vecs[13] = mk(1, 0, 1, 32'h0,   0, 4'b0000, 0, 1, 0, 32'h0,   0);
      vecs[14] = mk(1, 1, 0, 32'h60,  3, 4'b1000, 0, 1, 0, 32'h0,   0);
      vecs[15] = mk(1, 1, 0, 32'h70,  1, 4'b0000, 1, 1, 1, 32'h70,  1);
      vecs[16] = mk(1, 1, 1, 32'h80,  2, 4'b0000, 1, 1, 1, 32'h80,  2);
      vecs[17] = mk(1, 1, 0, 32'h90,  3, 4'b0000, 1, 0, 2, 32'h80,  2);
      vecs[18] = mk(0, 1, 1, 32'h99,  0, 4'b0000, 0, 1, 0, 32'h0,   0);
      vecs[19] = mk(1, 1, 0, 32'hA0,  1, 4'b0000, 1, 1, 1, 32'hA0,  1);
      vecs[20] = mk(1, 1, 0, 32'hB0,  3, 4'b0000, 1, 0, 2, 32'hA0,  1);
      vecs[21] = mk(1, 0, 0, 32'h0,   0, 4'b1000, 1, 1, 1, 32'hA0,  1);
      vecs[22] = mk(1, 0, 1, 32'h0,   0, 4'b0010, 0, 1, 0, 32'h0,   0);
      vecs[23] = mk(1, 1, 0, 32'hC0,  0, 4'b0000, 1, 1, 1, 32'hC0,  0);
      vecs[24] = mk(1, 1, 0, 32'hD0,  1, 4'b0001, 1, 1, 1, 32'hD0,  1);
      vecs[25] = mk(1, 0, 1, 32'h0,   0, 4'b0000, 0, 1, 0, 32'h0,   0);

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         drive(vecs[i].rstn, vecs[i].v, vecs[i].r, vecs[i].pc, vecs[i].th, vecs[i].fl);
         @(posedge clk);
         #1;
         act = {ovalid, ordy, occ, oth, opc, otgt, opred, oinstr};
         if (vecs[i].ev)
            exp = {1'b1, vecs[i].erdy, vecs[i].eocc, vecs[i].eth, vecs[i].epc,
                   vecs[i].epc + 32'h1000, vecs[i].epc[4], lanes_of(vecs[i].epc)};
         else
            exp = {1'b0, vecs[i].erdy, vecs[i].eocc, 155'd0};
         check($sformatf("vec%0d", i), act, exp);
      end

`ifdef PIPE_IF_DEC_STALL_CNT_EN
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'hE0, 2'd0, 4'h0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0);
      repeat (10) @(posedge clk);
      #1;
      check("stall_count_10", 160'(stall_cnt), 160'd10);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      check("stall_count_clr", 160'(stall_cnt), 160'd0);
      @(negedge clk);
      clr = 1'b0;
      rdy = 1'b1;
      @(posedge clk);
      #1;
      check("stall_drain", {159'd0, ovalid}, 160'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_if_dec_skid.md
Name: pipe_if_dec_skid

Overview:
- Parametrised successor to the IF/DEC pipeline register for the SMT core.
- Elastic two-entry skid stage between fetch and decode, using a valid/ready handshake.
- Carries NUM_SLOTS instruction lanes plus PC, prediction, branch target and thread ID.
- Supports per-thread selective flush, so a mispredict in one thread never kills the others' in-flight fetch bundles.

Parameters:
- ADDRESS_WIDTH, 32, PC and branch-target width.
- DATA_WIDTH, 22, width of one instruction lane.
- NUM_SLOTS, 4, instruction lanes per fetch bundle (>=1).
- NUM_THREADS, 4, hardware threads (>=1).
- THREAD_WIDTH, 2, thread-ID width; NUM_THREADS <= 2**THREAD_WIDTH, checked at elaboration.

Ports:
- i_Clk  in  1  clock.
- i_Reset_n  in  1  reset.
- i_Valid  in  1  fetch bundle present.
- o_Ready  out  1  stage can accept a bundle this cycle.
- i_PC  in  ADDRESS_WIDTH  bundle PC.
- i_Instruction  in  NUM_SLOTS*DATA_WIDTH  lanes; lane k at [k*DATA_WIDTH +: DATA_WIDTH].
- i_prediction  in  1  branch predictor taken bit.
- i_branch_target  in  ADDRESS_WIDTH  predicted target.
- i_thread  in  THREAD_WIDTH  owning thread.
- i_Flush_Mask  in  NUM_THREADS  bit t set = discard all bundles of thread t.
- o_Valid  out  1  bundle available to decode.
- i_Ready  in  1  decode accepts.
- o_PC, o_Instruction, o_prediction, o_branch_target, o_thread  out  widths as inputs  head bundle.
- o_Occupancy  out  2  entries held (0..2).

Interface decision: one clock, i_Clk; reset i_Reset_n is synchronous and active-low.

Behaviour:
- Storage: head register (drives the outputs) and skid register.
- State is the occupancy: EMPTY(0), ONE(1), FULL(2). o_Occupancy reflects the state.
- Handshake:
  - Accept = i_Valid & o_Ready.
  - Release = o_Valid & i_Ready.
  - o_Ready = (state != FULL); it depends only on registered state, never combinationally on i_Ready.
  - o_Valid = (state != EMPTY).
- Latency: 1 cycle. A bundle accepted in EMPTY is on the outputs with o_Valid=1 the next cycle.
- Transitions (no flush):
  - EMPTY + accept -> ONE.
  - ONE + accept, no release -> FULL; the new bundle goes to skid.
  - ONE + accept + release -> ONE; the new bundle goes to head.
  - ONE + release only -> EMPTY.
  - FULL + release -> ONE; skid moves to head.
  - FULL, no release -> hold.
- Ordering: strict FIFO order is preserved. Bundles are never reordered or duplicated.
- Flush (evaluated at the same edge, priority over handshake):
  - Any stored entry whose thread bit is set in i_Flush_Mask is invalidated.
  - An incoming bundle with its thread bit set is dropped even if accepted; it is not counted as accepted.
  - Surviving entries compact toward head, preserving order: a flushed head with a surviving skid means skid becomes head.
  - A release in the same cycle as a flush of the head still counts as consumed by decode. Decode must itself qualify with its own flush.
- Invalid entries hold all-zero payload; o_* payload is 0 whenever o_Valid=0.
- Reset (i_Reset_n=0 at edge): state EMPTY; all o_* = 0; o_Valid=0; o_Occupancy=0. o_Ready=1 from the first cycle after release. Inputs during reset cycles are ignored. A reset mid-operation discards both entries.
- Priority: reset > flush > handshake.

Optional Feature:
- Macro: PIPE_IF_DEC_STALL_CNT_EN.
- When defined:
  - Adds output o_Stall_Count (16 bits): counts cycles with o_Valid=1 and i_Ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
  - Also adds input i_Stall_Count_Clr, which zeroes the counter synchronously and takes priority over increment.
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- Shared package pipe_pkg: thread-ID typedef, fetch-bundle struct (PC, lanes, prediction, target, thread), and occupancy enum (EMPTY/ONE/FULL).
- One sub-module: pipe_bundle_reg. It is a single valid+payload entry with load, clear and flush-match (mask[thread]) logic, instantiated twice (head, skid).

Test Plan:
- Reset, then a single bundle (PC=0x100, thread=1, lanes 1,2,3,4) with i_Ready=1 -> next cycle o_Valid=1, o_PC=0x100, o_thread=1; following cycle o_Valid=0, all payload 0.
- Hold i_Ready=0 and offer PC 0x10, 0x20, 0x30 back-to-back -> o_Ready falls after the second accept, o_Occupancy=2, 0x30 is held off. Raise i_Ready -> 0x10, 0x20, 0x30 emerge in order with no loss or duplicate.
- FULL with head thread 0 and skid thread 2; pulse i_Flush_Mask=4'b0001 -> next cycle o_Occupancy=1, outputs show the thread-2 bundle.
- Offer a thread-3 bundle with i_Flush_Mask=4'b1000 in the same cycle while EMPTY -> o_Valid stays 0, o_Occupancy=0.
- Assert i_Reset_n=0 for one cycle while FULL -> next cycle o_Valid=0, o_Occupancy=0, o_Ready=1, all payload 0.
- With PIPE_IF_DEC_STALL_CNT_EN: hold o_Valid=1 and i_Ready=0 for 10 cycles -> o_Stall_Count=10; pulse i_Stall_Count_Clr -> 0.
